// File: rtl/rptr_empty_lvl_pkg.sv
// Shared defaults for the dual-clock FIFO read-side status logic.
package rptr_empty_lvl_pkg;
  localparam int ADDRSIZE_DEF  = 8;
  localparam int AE_THRESH_DEF = 2;
endpackage

// File: rtl/rptr_empty_lvl_gray2bin.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
module rptr_empty_lvl_gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end
endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer, empty, fill-level, almost-empty and sticky underflow logic of the
// dual-clock FIFO; sits between the write-pointer synchroniser and the FIFO RAM.
module rptr_empty_lvl
  import rptr_empty_lvl_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic          rd_en;

  rptr_empty_lvl_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin_s)
  );

  // Next-pointer view: the RAM address and all flags are computed from the post-read pointer
  // so a synchronous-read RAM presents the data on the same edge the pointer advances.
  always_comb begin
    rd_en      = rinc & ~rempty;
    rbinnext   = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    level_next = wbin_s - rbinnext;
  end

  assign raddr = rbinnext[ADDRSIZE-1:0];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (level_next <= AE_LVL);
      rlevel        <= level_next;
      runderflow    <= runderflow | (rinc & rempty);
    end
  end
endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Randomised and directed bench for rptr_empty_lvl against a read/write count model.
module tb_rptr_empty_lvl;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rinc = 1'b0;
  logic [AW:0]   rq2_wptr = '0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;
  logic          runderflow;

  int total = 0;
  int bad = 0;

  // Model: total words written and read since reset, plus the registered flags.
  int m_wr, m_rd, m_lvl;
  bit m_empty, m_uf;

  rptr_empty_lvl #(.ADDRSIZE(AW), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_lvl = 0; m_empty = 1; m_uf = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_rptr"},  int'(rptr),          int'(gray_of(m_rd)));
    chk({tag, "_empty"}, int'(rempty),        int'(m_empty));
    chk({tag, "_ae"},    int'(ralmost_empty), int'(m_lvl <= 2));
    chk({tag, "_lvl"},   int'(rlevel),        m_lvl);
    chk({tag, "_uf"},    int'(runderflow),    int'(m_uf));
  endtask

  // One rclk cycle: apply inputs just after an edge, check raddr, clock, check registered outputs.
  task automatic cycle(input logic ri, input int wn);
    bit hon;
    rinc = ri;
    m_wr = wn;
    rq2_wptr = gray_of(wn);
    #1;
    hon = ri && !m_empty;
    chk("raddr", int'(raddr), (m_rd + int'(hon)) % DEPTH);
    @(posedge rclk);
    if (ri && m_empty) m_uf = 1;
    m_rd += int'(hon);
    m_lvl = m_wr - m_rd;
    m_empty = (m_lvl == 0);
    #1;
    check_outs("cyc");
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #3;
    rinc = 1'b0;
    rrst = 1'b1;
    #1;
    chk("rst_rptr",  int'(rptr), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_empty", int'(rempty), 1);
    chk("rst_ae",    int'(ralmost_empty), 1);
    chk("rst_lvl",   int'(rlevel), 0);
    chk("rst_uf",    int'(runderflow), 0);
    rq2_wptr = '0;
    model_reset();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  initial begin
    int w;
    model_reset();
    #12;
    rrst = 1'b0;

    // Fill to 3, drain three words.
    cycle(0, 3);
    chk("t2_lvl3", int'(rlevel), 3);
    cycle(1, 3); chk("t2_rptr1", int'(rptr), 5'b00001);
    cycle(1, 3); chk("t2_rptr2", int'(rptr), 5'b00011);
    cycle(1, 3); chk("t2_rptr3", int'(rptr), 5'b00010);
    chk("t2_empty", int'(rempty), 1);

    // Underflow is sticky through later normal reads.
    cycle(1, 3);
    chk("t3_uf", int'(runderflow), 1);
    cycle(0, 4);
    cycle(1, 4);
    chk("t3_uf_hold", int'(runderflow), 1);

    // Mid-run async reset clears everything.
    cycle(0, 5);
    do_reset();

    // Wrap: writes advance one per cycle while reads keep pace, 20 reads in total.
    cycle(0, 1);
    for (int k = 2; k <= 20; k++) cycle(1, k);
    cycle(1, 20);
    chk("t4_rptr", int'(rptr), 5'b11110);
    chk("t4_empty", int'(rempty), 1);

    // Full view and simultaneous read/write.
    do_reset();
    for (int k = 1; k <= 16; k++) cycle(0, k);
    chk("t5_lvl16", int'(rlevel), 16);
    chk("t5_ae", int'(ralmost_empty), 0);
    for (int k = 0; k < 11; k++) cycle(1, 16);
    cycle(1, 17);
    chk("t6_lvl5", int'(rlevel), 5);
    chk("t6_empty", int'(rempty), 0);

    // Random traffic with writes bounded by the FIFO depth.
    do_reset();
    w = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1 && (w - m_rd) < DEPTH) w++;
      cycle(logic'($urandom_range(0, 2) != 0), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
